// File: rtl/priv_op_exec_if.sv
// Issue, TLB and writeback signal bundle for priv_op_exec.
// master = surrounding pipeline/TLB, slave = the execution unit.
interface priv_op_exec_if #(
   parameter int TLBIDX_W = 4
);
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          in_aluop;
   logic [4:0]          in_waddr;
   logic [31:0]         in_pc;
   logic [31:0]         csr_tid;
   logic [31:0]         csr_era;
   logic                tlb_req_valid;
   logic                tlb_req_ready;
   logic [1:0]          tlb_req_op;
   logic [TLBIDX_W-1:0] tlb_req_fill_idx;
   logic                tlb_resp_valid;
   logic                tlb_resp_hit;
   logic [TLBIDX_W-1:0] tlb_resp_index;
   logic                out_valid;
   logic                out_ready;
   logic                out_wen;
   logic [4:0]          out_waddr;
   logic [31:0]         out_wdata;
   logic                out_srch_valid;
   logic                out_srch_hit;
   logic [TLBIDX_W-1:0] out_srch_index;
   logic                out_flush;
   logic [31:0]         out_flush_pc;
   logic                out_tlb_err;

   modport master (
      output in_valid, in_aluop, in_waddr, in_pc, csr_tid, csr_era,
             tlb_req_ready, tlb_resp_valid, tlb_resp_hit, tlb_resp_index, out_ready,
      input  in_ready, tlb_req_valid, tlb_req_op, tlb_req_fill_idx,
             out_valid, out_wen, out_waddr, out_wdata, out_srch_valid, out_srch_hit,
             out_srch_index, out_flush, out_flush_pc, out_tlb_err
   );

   modport slave (
      input  in_valid, in_aluop, in_waddr, in_pc, csr_tid, csr_era,
             tlb_req_ready, tlb_resp_valid, tlb_resp_hit, tlb_resp_index, out_ready,
      output in_ready, tlb_req_valid, tlb_req_op, tlb_req_fill_idx,
             out_valid, out_wen, out_waddr, out_wdata, out_srch_valid, out_srch_hit,
             out_srch_index, out_flush, out_flush_pc, out_tlb_err
   );
endinterface

// File: rtl/priv_op_exec.sv
// Executes counter reads, ERTN and multi-cycle TLB ops; owns the 64-bit stable counter.
// Optional TLB response watchdog enabled by defining PRIV_TLB_TIMEOUT_EN.
module priv_op_exec #(
   parameter int TLBIDX_W    = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input logic           clk,
   input logic           rst_n,
   priv_op_exec_if.slave bus
);
   localparam logic [7:0] ALU_RDCNTVLW = 8'h50;
   localparam logic [7:0] ALU_RDCNTVHW = 8'h51;
   localparam logic [7:0] ALU_RDCNTID  = 8'h52;
   localparam logic [7:0] ALU_ERTN     = 8'h53;
   localparam logic [7:0] ALU_TLBSRCH  = 8'h54;
   localparam logic [7:0] ALU_TLBRD    = 8'h55;
   localparam logic [7:0] ALU_TLBWR    = 8'h56;
   localparam logic [7:0] ALU_TLBFILL  = 8'h57;

   localparam logic [1:0] OP_SRCH = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b10;
   localparam logic [1:0] OP_FILL = 2'b11;

   typedef enum logic [1:0] {IDLE, TLB_REQ, TLB_WAIT, DONE} state_t;

   state_t              state_q, state_d;
   logic [63:0]         cnt_q, cnt_d;
   logic                req_valid_q, req_valid_d;
   logic [1:0]          req_op_q, req_op_d;
   logic [TLBIDX_W-1:0] fill_idx_q, fill_idx_d;
   logic [31:0]         pc_q, pc_d;
   logic                out_valid_q, out_valid_d;
   logic                wen_q, wen_d;
   logic [4:0]          waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                srch_valid_q, srch_valid_d;
   logic                srch_hit_q, srch_hit_d;
   logic [TLBIDX_W-1:0] srch_index_q, srch_index_d;
   logic                flush_q, flush_d;
   logic [31:0]         flush_pc_q, flush_pc_d;
`ifdef PRIV_TLB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0]     wdog_q, wdog_d;
   logic                tlb_err_q, tlb_err_d;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 64'd1;
      req_valid_d  = req_valid_q;
      req_op_d     = req_op_q;
      fill_idx_d   = fill_idx_q;
      pc_d         = pc_q;
      out_valid_d  = out_valid_q;
      wen_d        = wen_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      srch_valid_d = srch_valid_q;
      srch_hit_d   = srch_hit_q;
      srch_index_d = srch_index_q;
      flush_d      = flush_q;
      flush_pc_d   = flush_pc_q;
`ifdef PRIV_TLB_TIMEOUT_EN
      wdog_d       = wdog_q;
      tlb_err_d    = tlb_err_q;
`endif
      case (state_q)
         IDLE: if (bus.in_valid) begin
            pc_d        = bus.in_pc;
            state_d     = DONE;
            out_valid_d = 1'b1;
            case (bus.in_aluop)
               ALU_RDCNTVLW: begin wen_d = 1'b1; waddr_d = bus.in_waddr; wdata_d = cnt_q[31:0];  end
               ALU_RDCNTVHW: begin wen_d = 1'b1; waddr_d = bus.in_waddr; wdata_d = cnt_q[63:32]; end
               ALU_RDCNTID:  begin wen_d = 1'b1; waddr_d = bus.in_waddr; wdata_d = bus.csr_tid;  end
               ALU_ERTN:     begin flush_d = 1'b1; flush_pc_d = bus.csr_era; end
               ALU_TLBSRCH, ALU_TLBRD, ALU_TLBWR, ALU_TLBFILL: begin
                  state_d     = TLB_REQ;
                  out_valid_d = 1'b0;
                  req_valid_d = 1'b1;
                  // TLB op codes are laid out so the low two bits are the request op
                  req_op_d    = bus.in_aluop[1:0];
                  fill_idx_d  = cnt_q[TLBIDX_W-1:0];
               end
               default: ;
            endcase
`ifdef PRIV_TLB_TIMEOUT_EN
            wdog_d = '0;
`endif
         end
         TLB_REQ: if (bus.tlb_req_ready) begin
            req_valid_d = 1'b0;
            state_d     = TLB_WAIT;
         end
         TLB_WAIT: if (bus.tlb_resp_valid) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            if (req_op_q == OP_SRCH) begin
               srch_valid_d = 1'b1;
               srch_hit_d   = bus.tlb_resp_hit;
               srch_index_d = bus.tlb_resp_index;
            end else if (req_op_q == OP_WR || req_op_q == OP_FILL) begin
               flush_d    = 1'b1;
               flush_pc_d = pc_q + 32'd4;
            end
         end
         DONE: if (bus.out_ready) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            wen_d        = 1'b0;
            waddr_d      = '0;
            wdata_d      = '0;
            srch_valid_d = 1'b0;
            srch_hit_d   = 1'b0;
            srch_index_d = '0;
            flush_d      = 1'b0;
            flush_pc_d   = '0;
            req_op_d     = OP_SRCH;
            fill_idx_d   = '0;
`ifdef PRIV_TLB_TIMEOUT_EN
            tlb_err_d    = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
`ifdef PRIV_TLB_TIMEOUT_EN
      // A response arriving on the expiry cycle wins over the timeout
      if (state_q == TLB_REQ || state_q == TLB_WAIT) begin
         wdog_d = wdog_q + 1'b1;
         if (state_d != DONE && wdog_q == WD_LAST) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            tlb_err_d    = 1'b1;
            req_valid_d  = 1'b0;
            flush_d      = 1'b1;
            flush_pc_d   = pc_q + 32'd4;
            srch_valid_d = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_valid_q  <= 1'b0;
         req_op_q     <= OP_SRCH;
         fill_idx_q   <= '0;
         pc_q         <= '0;
         out_valid_q  <= 1'b0;
         wen_q        <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         srch_valid_q <= 1'b0;
         srch_hit_q   <= 1'b0;
         srch_index_q <= '0;
         flush_q      <= 1'b0;
         flush_pc_q   <= '0;
`ifdef PRIV_TLB_TIMEOUT_EN
         wdog_q       <= '0;
         tlb_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_valid_q  <= req_valid_d;
         req_op_q     <= req_op_d;
         fill_idx_q   <= fill_idx_d;
         pc_q         <= pc_d;
         out_valid_q  <= out_valid_d;
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         srch_valid_q <= srch_valid_d;
         srch_hit_q   <= srch_hit_d;
         srch_index_q <= srch_index_d;
         flush_q      <= flush_d;
         flush_pc_q   <= flush_pc_d;
`ifdef PRIV_TLB_TIMEOUT_EN
         wdog_q       <= wdog_d;
         tlb_err_q    <= tlb_err_d;
`endif
      end
   end

   assign bus.in_ready         = (state_q == IDLE);
   assign bus.tlb_req_valid    = req_valid_q;
   assign bus.tlb_req_op       = req_op_q;
   assign bus.tlb_req_fill_idx = fill_idx_q;
   assign bus.out_valid        = out_valid_q;
   assign bus.out_wen          = wen_q;
   assign bus.out_waddr        = waddr_q;
   assign bus.out_wdata        = wdata_q;
   assign bus.out_srch_valid   = srch_valid_q;
   assign bus.out_srch_hit     = srch_hit_q;
   assign bus.out_srch_index   = srch_index_q;
   assign bus.out_flush        = flush_q;
   assign bus.out_flush_pc     = flush_pc_q;
`ifdef PRIV_TLB_TIMEOUT_EN
   assign bus.out_tlb_err      = tlb_err_q;
`else
   assign bus.out_tlb_err      = 1'b0;
`endif
endmodule

// File: tb/tb_priv_op_exec.sv
// Directed self-checking bench for priv_op_exec: counter reads, handshakes, TLB sequencing, flushes, reset.
module tb_priv_op_exec;
   localparam logic [7:0] ALU_NOP      = 8'h00;
   localparam logic [7:0] ALU_RDCNTVLW = 8'h50;
   localparam logic [7:0] ALU_RDCNTVHW = 8'h51;
   localparam logic [7:0] ALU_RDCNTID  = 8'h52;
   localparam logic [7:0] ALU_ERTN     = 8'h53;
   localparam logic [7:0] ALU_TLBSRCH  = 8'h54;
   localparam logic [7:0] ALU_TLBWR    = 8'h56;
   localparam logic [7:0] ALU_TLBFILL  = 8'h57;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   priv_op_exec_if #(.TLBIDX_W(4)) bus ();
   priv_op_exec #(.TLBIDX_W(4), .TIMEOUT_CYC(255)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] cyc;
   logic [63:0] exp_cnt;

   // Independent model of the stable counter
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= '0;
      else        cyc <= cyc + 64'd1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [7:0] op, input logic [4:0] wa, input logic [31:0] pc);
      chk("in_ready_before_issue", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b1;
      bus.in_aluop = op;
      bus.in_waddr = wa;
      bus.in_pc    = pc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      $display("issue aluop=%02h waddr=%0d pc=%08h", op, wa, pc);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_aluop = '0; bus.in_waddr = '0; bus.in_pc = '0;
      bus.csr_tid = '0; bus.csr_era = '0; bus.tlb_req_ready = 1'b0;
      bus.tlb_resp_valid = 1'b0; bus.tlb_resp_hit = 1'b0; bus.tlb_resp_index = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_req_valid", {63'd0, bus.tlb_req_valid}, 64'd0);
      chk("rst_flush", {63'd0, bus.out_flush}, 64'd0);
      chk("rst_wdata", {32'd0, bus.out_wdata}, 64'd0);
      rst_n = 1'b1;

      // 1: counter low/high after 10 idle cycles
      repeat (10) @(negedge clk);
      exp_cnt = cyc;
      issue(ALU_RDCNTVLW, 5'd5, 32'h0);
      chk("vlw_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("vlw_wen", {63'd0, bus.out_wen}, 64'd1);
      chk("vlw_waddr", {59'd0, bus.out_waddr}, 64'd5);
      chk("vlw_wdata", {32'd0, bus.out_wdata}, {32'd0, exp_cnt[31:0]});
      chk("vlw_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
      chk("vlw_clear_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("vlw_clear_wdata", {32'd0, bus.out_wdata}, 64'd0);
      issue(ALU_RDCNTVHW, 5'd6, 32'h0);
      chk("vhw_wdata", {32'd0, bus.out_wdata}, 64'd0);
      chk("vhw_waddr", {59'd0, bus.out_waddr}, 64'd6);
      @(negedge clk);

      // 3: RDCNTID with writeback back-pressure
      bus.csr_tid = 32'h1234_5678;
      bus.out_ready = 1'b0;
      issue(ALU_RDCNTID, 5'd9, 32'h0);
      bus.csr_tid = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         chk("id_hold_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("id_hold_wdata", {32'd0, bus.out_wdata}, 64'h1234_5678);
         chk("id_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("id_release_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("id_release_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // 4: TLBSRCH with delayed ready; a response in the handshake cycle is ignored
      bus.tlb_req_ready = 1'b0;
      issue(ALU_TLBSRCH, 5'd1, 32'h1C00_0000);
      chk("srch_req_valid", {63'd0, bus.tlb_req_valid}, 64'd1);
      chk("srch_req_op", {62'd0, bus.tlb_req_op}, 64'd0);
      @(negedge clk);
      chk("srch_req_hold", {63'd0, bus.tlb_req_valid}, 64'd1);
      @(negedge clk);
      chk("srch_req_hold2", {63'd0, bus.tlb_req_valid}, 64'd1);
      bus.tlb_req_ready = 1'b1;
      bus.tlb_resp_valid = 1'b1; bus.tlb_resp_hit = 1'b0; bus.tlb_resp_index = 4'h3;
      @(negedge clk);
      bus.tlb_req_ready = 1'b0; bus.tlb_resp_valid = 1'b0;
      chk("srch_req_dropped", {63'd0, bus.tlb_req_valid}, 64'd0);
      chk("srch_early_resp_ignored", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
      bus.tlb_resp_valid = 1'b1; bus.tlb_resp_hit = 1'b1; bus.tlb_resp_index = 4'hA;
      @(negedge clk);
      bus.tlb_resp_valid = 1'b0; bus.tlb_resp_hit = 1'b0; bus.tlb_resp_index = 4'h0;
      chk("srch_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("srch_valid", {63'd0, bus.out_srch_valid}, 64'd1);
      chk("srch_hit", {63'd0, bus.out_srch_hit}, 64'd1);
      chk("srch_index", {60'd0, bus.out_srch_index}, 64'hA);
      chk("srch_wen", {63'd0, bus.out_wen}, 64'd0);
      chk("srch_flush", {63'd0, bus.out_flush}, 64'd0);
      @(negedge clk);
      chk("srch_clear", {63'd0, bus.out_srch_valid}, 64'd0);

      // 5: TLBFILL at minimum latency, then ERTN and a plain NOP
      bus.tlb_req_ready = 1'b1;
      exp_cnt = cyc;
      issue(ALU_TLBFILL, 5'd2, 32'h1C00_0FFC);
      chk("fill_req_valid", {63'd0, bus.tlb_req_valid}, 64'd1);
      chk("fill_req_op", {62'd0, bus.tlb_req_op}, 64'd3);
      chk("fill_idx", {60'd0, bus.tlb_req_fill_idx}, {60'd0, exp_cnt[3:0]});
      @(negedge clk);
      bus.tlb_resp_valid = 1'b1;
      @(negedge clk);
      bus.tlb_resp_valid = 1'b0;
      chk("fill_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("fill_flush", {63'd0, bus.out_flush}, 64'd1);
      chk("fill_flush_pc", {32'd0, bus.out_flush_pc}, 64'h1C00_1000);
      chk("fill_wen", {63'd0, bus.out_wen}, 64'd0);
      chk("fill_tlb_err", {63'd0, bus.out_tlb_err}, 64'd0);
      @(negedge clk);
      bus.csr_era = 32'h1C00_0040;
      issue(ALU_ERTN, 5'd3, 32'h1C00_2000);
      chk("ertn_flush", {63'd0, bus.out_flush}, 64'd1);
      chk("ertn_flush_pc", {32'd0, bus.out_flush_pc}, 64'h1C00_0040);
      chk("ertn_wen", {63'd0, bus.out_wen}, 64'd0);
      @(negedge clk);
      issue(ALU_NOP, 5'd4, 32'h0);
      chk("nop_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("nop_wen", {63'd0, bus.out_wen}, 64'd0);
      chk("nop_flush", {63'd0, bus.out_flush}, 64'd0);
      @(negedge clk);

      // 2: counter carry from low to high word, then full 64-bit wrap
      force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
      #1 release dut.cnt_q;
      @(negedge clk);
      issue(ALU_RDCNTVLW, 5'd7, 32'h0);
      chk("carry_low", {32'd0, bus.out_wdata}, 64'd0);
      @(negedge clk);
      issue(ALU_RDCNTVHW, 5'd7, 32'h0);
      chk("carry_high", {32'd0, bus.out_wdata}, 64'd1);
      @(negedge clk);
      force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.cnt_q;
      @(negedge clk);
      issue(ALU_RDCNTVHW, 5'd8, 32'h0);
      chk("wrap_high", {32'd0, bus.out_wdata}, 64'd0);
      @(negedge clk);

      // 6: TLBWR with no response
      bus.tlb_req_ready = 1'b1;
      issue(ALU_TLBWR, 5'd0, 32'h1C00_0100);
`ifdef PRIV_TLB_TIMEOUT_EN
      begin
         int n;
         n = 1;
         while (!bus.out_valid && n < 400) begin
            @(negedge clk);
            n++;
         end
         chk("tmo_latency", 64'(n), 64'd256);
         chk("tmo_err", {63'd0, bus.out_tlb_err}, 64'd1);
         chk("tmo_flush", {63'd0, bus.out_flush}, 64'd1);
         chk("tmo_flush_pc", {32'd0, bus.out_flush_pc}, 64'h1C00_0104);
         chk("tmo_srch", {63'd0, bus.out_srch_valid}, 64'd0);
         chk("tmo_req_valid", {63'd0, bus.tlb_req_valid}, 64'd0);
         @(negedge clk);
         chk("tmo_clear_err", {63'd0, bus.out_tlb_err}, 64'd0);
      end
      issue(ALU_TLBWR, 5'd0, 32'h1C00_0100);
`else
      repeat (20) @(negedge clk);
      chk("wait_no_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("wait_no_err", {63'd0, bus.out_tlb_err}, 64'd0);
      chk("wait_in_ready", {63'd0, bus.in_ready}, 64'd0);
`endif
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("midrst_req_valid", {63'd0, bus.tlb_req_valid}, 64'd0);
      chk("midrst_flush", {63'd0, bus.out_flush}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.tlb_resp_valid = 1'b1; bus.tlb_resp_hit = 1'b1;
      @(negedge clk);
      bus.tlb_resp_valid = 1'b0; bus.tlb_resp_hit = 1'b0;
      chk("late_resp_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("late_resp_srch", {63'd0, bus.out_srch_valid}, 64'd0);
      exp_cnt = cyc;
      issue(ALU_RDCNTVLW, 5'd10, 32'h0);
      chk("post_rst_wdata", {32'd0, bus.out_wdata}, {32'd0, exp_cnt[31:0]});
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
